dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's MEM-stage load/store requests.
- Stores words in an internal array and inserts a programmable number of wait states.
- Drives a stall back to the initiator until each access completes.
- Replaces the zero-wait data memory so the pipeline's freeze/stall path can be exercised.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
LATENCY, 2, wait cycles inserted between acceptance and response; legal range 0..15.
BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
mem_read  in  1  load request; held stable by the initiator until resp_valid.
mem_write  in  1  store request; held stable until resp_valid.
mem_addr  in  32  byte address.
mem_wdata  in  32  store data.
mem_be  in  4  byte enables for stores; bit i enables byte lane i (bits 8i+7..8i).
stall  out  1  combinational; high while a request is pending and not yet answered.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  load data; valid only while resp_valid is high.
resp_err  out  1  error flag; valid only while resp_valid is high.
rd_count  out  16  completed-load counter (optional feature).
wr_count  out  16  completed-store counter (optional feature).

Behaviour:
- Reset values and effects:
  - Outputs: resp_valid=0, resp_rdata=0, resp_err=0, counters=0, FSM in IDLE, wait counter=0.
  - Array contents are not cleared.
- req = mem_read | mem_write.
- stall = req & ~resp_valid.
- FSM IDLE:
  - If req, latch addr/wdata/be/kind.
  - Go to WAIT with cnt=LATENCY when LATENCY>0, otherwise go directly to RESP.
- FSM WAIT:
  - cnt decrements each cycle.
  - When cnt==1, next state is RESP.
- FSM RESP:
  - resp_valid=1 for exactly this one cycle.
  - The store commits to the array on the clock edge that enters RESP.
  - resp_rdata is registered on that same edge.
  - Next state is IDLE unconditionally.
  - No new request is accepted while in RESP.
- Latency: resp_valid rises exactly LATENCY+1 cycles after the first cycle req is sampled high in IDLE.
- Back-to-back: a request present in the cycle after RESP is accepted immediately, so peak throughput is 1 access per LATENCY+2 cycles.
- Word index = (mem_addr - BASE_ADDR) >> 2, taken modulo nothing; any out-of-range index is an error.
- Loads return the full word. mem_be is ignored for loads.
- Stores write only the enabled lanes. be=0000 completes normally with no change to the array.
- Error conditions (checked on the latched request):
  - Misaligned address: addr[1:0]!=0.
  - Index >= DEPTH_WORDS.
  - mem_read and mem_write both high.
- On error: resp_err=1 with the response, resp_rdata=0, no array write.
- Changing request inputs while in WAIT has no effect; the latched copy is used.
- Dropping req mid-WAIT does not abort the access; the response still issues.
- Reset asserted in any state returns the FSM to IDLE next edge. Any in-flight store that has not reached RESP is discarded.
- Read-after-write: a load accepted after a store's RESP cycle observes the new data.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - rd_count increments on each error-free load response; wr_count increments on each error-free store response.
  - Both are 16-bit, saturate at 16'hFFFF and are cleared by reset.
- Undefined: rd_count and wr_count are tied to 0, and no counter flops are inferred.

Decomposition:
- Package dmem_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP).
  - Constants WORD_W=32, BE_W=4, CNT_W=4.
  - Function be_merge(old, new, be) returning the byte-lane merged word.
- Sub-module dmem_array: single-port synchronous storage with per-lane write enables and a registered read port, parameterised by DEPTH_WORDS.
- The FSM, error checks and counters live in dmem_responder.

Test Plan:
- LATENCY=2: store addr 0x10, data 0xDEADBEEF, be=1111 -> stall high 3 cycles, resp_valid on cycle 3, resp_err=0. A following load from 0x10 -> resp_rdata=0xDEADBEEF.
- Partial store: be=0010, data 0x0000AB00 to 0x10 -> subsequent load returns 0xDEADABEF.
- Error cases -> resp_err=1, rdata=0, array unchanged:
  - Misaligned load from 0x13.
  - Store to 0x400 (DEPTH_WORDS=256).
  - mem_read and mem_write both high.
- LATENCY=0: back-to-back loads from 0x0 and 0x4 -> resp_valid on cycles 1 and 3, stall=1 only on cycles 0 and 2.
- Reset mid-operation: reset asserted during WAIT of a store 0x55 to 0x20 -> no resp_valid, outputs 0, subsequent load from 0x20 returns the prior contents.
- With DMEM_STATS_EN: 3 good loads, 2 good stores, 1 error -> rd_count=3, wr_count=2. After reset both read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Replace only the byte lanes selected by be; other lanes keep old_word.
    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage split into byte lanes, per-lane write enable, registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_q;

            // Read-first: a write and a read of the same word return the old byte.
            always_ff @(posedge clk) begin
                if (we && be[gi]) lane_mem[addr] <= wdata[8*gi +: 8];
                lane_rd_q <= lane_mem[addr];
            end

            assign rdata[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and a stall back to the MEM stage.
// Define DMEM_STATS_EN to build the saturating completed-load/store counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    input  logic [BE_W-1:0]   mem_be,
    output logic              stall,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int              ADDR_W  = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic                rd_ok_q, rd_ok_d;

    logic                req, in_idle, fire;
    logic                cur_rd, cur_wr, cur_err;
    logic [31:0]         cur_addr, offs, idx;
    logic [WORD_W-1:0]   cur_wdata, arr_rdata;
    logic [BE_W-1:0]     cur_be;
    logic                arr_we;

    // In IDLE the live inputs drive the array directly so LATENCY=0 still answers in one cycle.
    always_comb begin
        req       = mem_read | mem_write;
        in_idle   = (state_q == IDLE);
        cur_rd    = in_idle ? mem_read  : rd_q;
        cur_wr    = in_idle ? mem_write : wr_q;
        cur_addr  = in_idle ? mem_addr  : addr_q;
        cur_wdata = in_idle ? mem_wdata : wdata_q;
        cur_be    = in_idle ? mem_be    : be_q;
        offs      = cur_addr - BASE_ADDR;
        idx       = offs >> 2;
        cur_err   = (cur_addr[1:0] != 2'b00)
                  | (idx >= WORD_W'(DEPTH_WORDS))
                  | (cur_rd & cur_wr);

        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    be_d    = mem_be;
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    if (LAT_C != '0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_C;
                    end else begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        resp_valid_d = fire;
        resp_err_d   = fire & cur_err;
        rd_ok_d      = fire & cur_rd & ~cur_err;
        // A reset landing on the commit edge must discard the store.
        arr_we       = fire & cur_wr & ~cur_err & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rd_ok_q      <= rd_ok_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (cur_be),
        .addr  (idx[ADDR_W-1:0]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    assign stall      = req & ~resp_valid_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rd_ok_q ? arr_rdata : '0;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (fire & cur_rd & ~cur_err & (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
        if (fire & cur_wr & ~cur_err & (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        mem_read, mem_write, stall, resp_valid, resp_err;
    logic [31:0] mem_addr, mem_wdata, resp_rdata;
    logic [3:0]  mem_be;
    logic [15:0] rd_count, wr_count;

    logic        rd_z, wr_z, stall_z, valid_z, err_z;
    logic [31:0] addr_z, wdata_z, rdata_z;
    logic [3:0]  be_z;
    logic [15:0] rdc_z, wrc_z;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) dut_z (
        .clk(clk), .reset(reset), .mem_read(rd_z), .mem_write(wr_z),
        .mem_addr(addr_z), .mem_wdata(wdata_z), .mem_be(be_z),
        .stall(stall_z), .resp_valid(valid_z), .resp_rdata(rdata_z),
        .resp_err(err_z), .rd_count(rdc_z), .wr_count(wrc_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic acc(input bit z, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit drop,
                       output logic [31:0] rdata, output logic err, output int lat, output int sc);
        if (z) begin rd_z = rd; wr_z = wr; addr_z = a; wdata_z = d; be_z = be; end
        else   begin mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d; mem_be = be; end
        lat = -1; sc = 0; rdata = 'x; err = 1'bx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (z ? stall_z : stall) sc++;
            if (z ? valid_z : resp_valid) begin
                lat = k; rdata = z ? rdata_z : resp_rdata; err = z ? err_z : resp_err;
                break;
            end
            if (drop && k == 0) begin
                @(posedge clk); #1;
                mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'h13; mem_wdata = 32'hFFFF_FFFF;
            end
        end
        if (lat < 0) check("resp_timeout", 32'hFFFF_FFFF, 32'h0);
        @(posedge clk); #1;
        rd_z = 1'b0; wr_z = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        $display("acc z=%0d rd=%0d wr=%0d addr=%h wdata=%h be=%b -> lat=%0d stall_cycles=%0d err=%b rdata=%h",
                 z, rd, wr, a, d, be, lat, sc, err, rdata);
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat, sc;
    bit          seen;
    logic [4:0]  sv, rv;
    logic [31:0] d1, d3;

    initial begin
        reset = 1'b1;
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_be = 0;
        rd_z = 0; wr_z = 0; addr_z = 0; wdata_z = 0; be_z = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err",   {31'd0, resp_err},   32'd0);
        check("rst_rdata", resp_rdata,          32'd0);
        check("rst_stall", {31'd0, stall},      32'd0);
        check("rst_rdcnt", {16'd0, rd_count},   32'd0);
        check("rst_wrcnt", {16'd0, wr_count},   32'd0);
        @(posedge clk); #1;

        // Full store, then load back with LATENCY=2 timing.
        acc(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, rdata, err, lat, sc);
        check("st_lat", 32'(lat), 32'd3);
        check("st_stall", 32'(sc), 32'd3);
        check("st_err", {31'd0, err}, 32'd0);
        acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        check("ld_lat", 32'(lat), 32'd3);
        check("ld_data", rdata, 32'hDEAD_BEEF);
        check("ld_err", {31'd0, err}, 32'd0);

        // Partial store on lane 1 only.
        acc(0, 0, 1, 32'h10, 32'h0000_AB00, 4'b0010, 0, rdata, err, lat, sc);
        acc(0, 1, 0, 32'h10, 32'h0, 4'b1111, 0, rdata, err, lat, sc);
        check("part_data", rdata, 32'hDEAD_ABEF);
        acc(0, 0, 1, 32'h0, 32'h1111_1111, 4'b1111, 0, rdata, err, lat, sc);

        // Error cases: no array change, rdata forced to zero.
        acc(0, 1, 0, 32'h13, 32'h0, 4'b1111, 0, rdata, err, lat, sc);
        check("mis_err", {31'd0, err}, 32'd1);
        check("mis_rdata", rdata, 32'd0);
        check("mis_lat", 32'(lat), 32'd3);
        acc(0, 0, 1, 32'h400, 32'h1234_5678, 4'b1111, 0, rdata, err, lat, sc);
        check("oob_err", {31'd0, err}, 32'd1);
        acc(0, 1, 1, 32'h10, 32'hFFFF_FFFF, 4'b1111, 0, rdata, err, lat, sc);
        check("both_err", {31'd0, err}, 32'd1);
        check("both_rdata", rdata, 32'd0);
        acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        check("err_keep10", rdata, 32'hDEAD_ABEF);
        acc(0, 1, 0, 32'h0, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        check("oob_keep0", rdata, 32'h1111_1111);

        // Request dropped and altered mid-WAIT still completes with latched copy.
        acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 1, rdata, err, lat, sc);
        check("drop_lat", 32'(lat), 32'd3);
        check("drop_data", rdata, 32'hDEAD_ABEF);
        check("drop_err", {31'd0, err}, 32'd0);

        // Reset on the last WAIT cycle of a store discards it.
        acc(0, 0, 1, 32'h20, 32'hAAAA_AAAA, 4'b1111, 0, rdata, err, lat, sc);
        mem_write = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h0000_0055; mem_be = 4'b1111;
        @(negedge clk);
        check("rst_op_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        check("rst_op_novalid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || resp_err || resp_rdata != 32'd0 || stall) seen = 1;
        end
        check("rst_op_quiet", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        acc(0, 1, 0, 32'h20, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        check("rst_op_keep", rdata, 32'hAAAA_AAAA);

        // Counter activity since that reset: 3 good loads, 2 good stores, 1 error.
        acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        acc(0, 1, 0, 32'h0, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        acc(0, 0, 1, 32'h24, 32'h2424_2424, 4'b1111, 0, rdata, err, lat, sc);
        acc(0, 0, 1, 32'h28, 32'h2828_2828, 4'b1111, 0, rdata, err, lat, sc);
        acc(0, 1, 0, 32'h21, 32'h0, 4'b0000, 0, rdata, err, lat, sc);
        check("err_flag", {31'd0, err}, 32'd1);
        @(negedge clk);
`ifdef DMEM_STATS_EN
        check("rd_count", {16'd0, rd_count}, 32'd3);
        check("wr_count", {16'd0, wr_count}, 32'd2);
`else
        check("rd_count", {16'd0, rd_count}, 32'd0);
        check("wr_count", {16'd0, wr_count}, 32'd0);
`endif
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rd_count_rst", {16'd0, rd_count}, 32'd0);
        check("wr_count_rst", {16'd0, wr_count}, 32'd0);
        @(posedge clk); #1;

        // LATENCY=0 instance: seed two words, then back-to-back loads.
        acc(1, 0, 1, 32'h0, 32'hA0A0_A0A0, 4'b1111, 0, rdata, err, lat, sc);
        check("z_st_lat", 32'(lat), 32'd1);
        acc(1, 0, 1, 32'h4, 32'h0B0B_0B0B, 4'b1111, 0, rdata, err, lat, sc);
        d1 = '0; d3 = '0;
        for (int c = 0; c < 5; c++) begin
            rd_z = (c < 4); addr_z = (c < 2) ? 32'h0 : 32'h4;
            @(negedge clk);
            sv[c] = stall_z; rv[c] = valid_z;
            if (c == 1) d1 = rdata_z;
            if (c == 3) d3 = rdata_z;
            @(posedge clk); #1;
        end
        rd_z = 1'b0;
        $display("acc z=1 b2b loads 0x0,0x4 -> stall=%b valid=%b d1=%h d3=%h", sv, rv, d1, d3);
        check("z_b2b_stall", {27'd0, sv}, 32'b00101);
        check("z_b2b_valid", {27'd0, rv}, 32'b01010);
        check("z_b2b_d1", d1, 32'hA0A0_A0A0);
        check("z_b2b_d3", d3, 32'h0B0B_0B0B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
